cdc_pulse_arbiter: RTL and testbench

CDC_PULSE_ARBITER -- requirements
Module: cdc_pulse_arbiter

---
 rtl/cdc_pulse_arbiter_pkg.sv | 15 +
 rtl/cdc_pulse_arbiter_if.sv | 24 ++
 rtl/cdc_pulse_arbiter_rr_select.sv | 32 +++
 rtl/cdc_pulse_arbiter.sv | 112 +++++++++++
 tb/tb_cdc_pulse_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pulse_arbiter_pkg.sv
// Shared types and default constants for the pulse-CDC arbiter.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_GAP     = 2;

endpackage

// File: rtl/cdc_pulse_arbiter_if.sv
// Request/channel/status bundle between requesters and the pulse-CDC arbiter.
interface cdc_pulse_arbiter_if #(
  parameter int N_REQ = cdc_pkg::DEF_N_REQ
);
  logic [N_REQ-1:0]         reqPulse;
  logic                     chAck;
  logic                     clrErr;
  logic                     chPulse;
  logic [$clog2(N_REQ)-1:0] chId;
  logic                     busy;
  logic [N_REQ-1:0]         pending;
  logic [N_REQ-1:0]         overflow;
  logic                     timedOut;

  modport master (
    output reqPulse, chAck, clrErr,
    input  chPulse, chId, busy, pending, overflow, timedOut
  );

  modport slave (
    input  reqPulse, chAck, clrErr,
    output chPulse, chId, busy, pending, overflow, timedOut
  );
endinterface

// File: rtl/cdc_pulse_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module rr_select #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_start,
  output logic [$clog2(N_REQ)-1:0] o_grant,
  output logic                     o_valid
);
  localparam int W  = $clog2(N_REQ);
  localparam int W1 = W + 1;

  logic [W1-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_start} + W1'(k);
      if (w_idx >= W1'(N_REQ)) begin
        w_idx = w_idx - W1'(N_REQ);
      end
      if (i_req[w_idx[W-1:0]]) begin
        o_grant = w_idx[W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_pulse_arbiter.sv
// Round-robin arbiter sharing one pulse-CDC channel among N_REQ event requesters.
module cdc_pulse_arbiter
  import cdc_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input  logic                clk,
  input  logic                rst_n,
  cdc_pulse_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 2);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_overflow;
  logic             r_timedOut;
  logic             r_chPulse;
  logic [IW-1:0]    r_chId;
  logic             r_busy;
  logic [IW-1:0]    r_start;
  logic [TW-1:0]    r_timer;
  logic [3:0]       r_gap;

  logic [IW-1:0]    w_grant;
  logic             w_valid;
  logic [N_REQ-1:0] w_clr_mask;
  logic [N_REQ-1:0] w_ovf_set;
  logic             w_to_set;

  rr_select #(.N_REQ(N_REQ)) u_rr (
    .i_req   (r_pending),
    .i_start (r_start),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  // The granted bit is released in ISSUE; a fresh pulse that same cycle re-arms it cleanly.
  assign w_clr_mask = (r_state == ST_ISSUE) ? (N_REQ'(1) << r_chId) : '0;
  assign w_ovf_set  = bus.reqPulse & r_pending & ~w_clr_mask;
  assign w_to_set   = (r_state == ST_WAIT) && !bus.chAck && (r_timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_overflow <= '0;
      r_timedOut <= 1'b0;
      r_chPulse  <= 1'b0;
      r_chId     <= '0;
      r_busy     <= 1'b0;
      r_start    <= '0;
      r_timer    <= '0;
      r_gap      <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_clr_mask) | bus.reqPulse;
      r_overflow <= (bus.clrErr ? '0 : r_overflow) | w_ovf_set;
      r_timedOut <= (bus.clrErr ? 1'b0 : r_timedOut) | w_to_set;
      r_chPulse  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_chId    <= w_grant;
            r_start   <= (w_grant == LAST_IDX) ? '0 : w_grant + IW'(1);
            r_chPulse <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.chAck || w_to_set) begin
            if (GAP == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_gap   <= '0;
              r_state <= ST_GUARD;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_GUARD: begin
          if (r_gap == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.chPulse  = r_chPulse;
  assign bus.chId     = r_chId;
  assign bus.busy     = r_busy;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;
  assign bus.timedOut = r_timedOut;

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Directed bench for cdc_pulse_arbiter with N_REQ=4, TIMEOUT=64, GAP=2.
module tb_cdc_pulse_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cdc_pulse_arbiter_if #(.N_REQ(4)) bus_if ();

  cdc_pulse_arbiter #(.N_REQ(4), .TIMEOUT(64), .GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus_if.reqPulse = '0;
    bus_if.chAck = 1'b0;
    bus_if.clrErr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Returns in the cycle chPulse is high (ISSUE), or ok=0 after 200 cycles.
  task automatic wait_pulse(output bit ok, output logic [1:0] id);
    ok = 1'b0;
    id = '0;
    for (int k = 0; k < 200; k++) begin
      if (bus_if.chPulse === 1'b1) begin
        ok = 1'b1;
        id = bus_if.chId;
        break;
      end
      step(1);
    end
  endtask

  task automatic ack_after(input int n);
    step(n);
    bus_if.chAck = 1'b1;
    step(1);
    bus_if.chAck = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.reqPulse = 4'b1111;
    bus_if.chAck = 1'b1;
    bus_if.clrErr = 1'b0;
    step(2);
    checks++;
    if ({bus_if.chPulse, bus_if.busy, bus_if.timedOut} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: chPulse/busy/timedOut got %b expected 000",
               {bus_if.chPulse, bus_if.busy, bus_if.timedOut});
    end
    checks++;
    if (bus_if.pending !== 4'b0000 || bus_if.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_vectors: pending=%b overflow=%b expected 0000/0000",
               bus_if.pending, bus_if.overflow);
    end
    checks++;
    if (bus_if.chId !== 2'd0) begin
      errors++;
      $display("FAIL reset_chId: got %0d expected 0", bus_if.chId);
    end
    bus_if.reqPulse = '0;
    bus_if.chAck = 1'b0;
    rst_n = 1'b1;
    step(1);
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    bus_if.reqPulse = 4'b0100;           // cycle t
    step(1);                             // t+1
    bus_if.reqPulse = '0;
    checks++;
    if (bus_if.pending !== 4'b0100 || bus_if.chPulse !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: pending=%b chPulse=%b expected 0100/0", bus_if.pending, bus_if.chPulse);
    end
    step(1);                             // t+2
    checks++;
    if (bus_if.chPulse !== 1'b1 || bus_if.chId !== 2'd2 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t2: chPulse=%b chId=%0d busy=%b expected 1/2/1",
               bus_if.chPulse, bus_if.chId, bus_if.busy);
    end
    step(1);                             // t+3
    checks++;
    if (bus_if.chPulse !== 1'b0 || bus_if.pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_t3: chPulse=%b pending=%b expected 0/0000", bus_if.chPulse, bus_if.pending);
    end
    step(2);                             // t+5
    bus_if.chAck = 1'b1;
    step(1);                             // t+6
    bus_if.chAck = 1'b0;
    step(1);                             // t+7
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.chId !== 2'd2) begin
      errors++;
      $display("FAIL single_guard: busy=%b chId=%0d expected 1/2", bus_if.busy, bus_if.chId);
    end
    step(1);                             // t+8
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: busy=%b expected 0", bus_if.busy);
    end
    $display("test_single done");
  endtask

  task automatic test_simultaneous();
    bit         ok;
    logic [1:0] id;
    apply_reset();
    bus_if.reqPulse = 4'b1111;
    step(1);
    bus_if.reqPulse = '0;
    checks++;
    if (bus_if.pending !== 4'b1111) begin
      errors++;
      $display("FAIL simul_pending: got %b expected 1111", bus_if.pending);
    end
    for (int k = 0; k < 4; k++) begin
      wait_pulse(ok, id);
      checks++;
      if (!ok || id !== 2'(k)) begin
        errors++;
        $display("FAIL simul_grant%0d: ok=%0d chId=%0d expected ok=1 chId=%0d", k, ok, id, k);
      end
      ack_after(3);
    end
    step(4);
    checks++;
    if (bus_if.overflow !== 4'b0000 || bus_if.pending !== 4'b0000 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_end: overflow=%b pending=%b busy=%b expected 0000/0000/0",
               bus_if.overflow, bus_if.pending, bus_if.busy);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_fairness();
    bit         ok;
    logic [1:0] id;
    apply_reset();
    bus_if.reqPulse = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(ok, id);
      checks++;
      if (!ok || id !== 2'(k % 2)) begin
        errors++;
        $display("FAIL fair_grant%0d: ok=%0d chId=%0d expected ok=1 chId=%0d", k, ok, id, k % 2);
      end
      ack_after(2);
    end
    bus_if.reqPulse = '0;
    $display("test_fairness done");
  endtask

  task automatic test_coalesce();
    bit         ok;
    logic [1:0] id;
    int         n;
    apply_reset();
    bus_if.reqPulse = 4'b0001;
    step(1);
    bus_if.reqPulse = '0;
    wait_pulse(ok, id);                  // ISSUE for id 0
    checks++;
    if (!ok || id !== 2'd0) begin
      errors++;
      $display("FAIL coal_first: ok=%0d chId=%0d expected ok=1 chId=0", ok, id);
    end
    step(1);                             // WAIT
    bus_if.reqPulse = 4'b0010;
    step(1);
    bus_if.reqPulse = '0;
    checks++;
    if (bus_if.pending !== 4'b0010 || bus_if.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL coal_pulse1: pending=%b overflow=%b expected 0010/0000", bus_if.pending, bus_if.overflow);
    end
    bus_if.reqPulse = 4'b0010;
    step(1);
    bus_if.reqPulse = '0;
    checks++;
    if (bus_if.overflow !== 4'b0010) begin
      errors++;
      $display("FAIL coal_overflow: got %b expected 0010", bus_if.overflow);
    end
    bus_if.reqPulse = 4'b0010;           // set and clear together: set wins
    bus_if.clrErr = 1'b1;
    step(1);
    bus_if.reqPulse = '0;
    bus_if.clrErr = 1'b0;
    checks++;
    if (bus_if.overflow !== 4'b0010) begin
      errors++;
      $display("FAIL coal_set_wins: got %b expected 0010", bus_if.overflow);
    end
    bus_if.chAck = 1'b1;
    step(1);
    bus_if.chAck = 1'b0;
    wait_pulse(ok, id);
    checks++;
    if (!ok || id !== 2'd1) begin
      errors++;
      $display("FAIL coal_second: ok=%0d chId=%0d expected ok=1 chId=1", ok, id);
    end
    ack_after(2);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (bus_if.chPulse === 1'b1) n++;
    end
    checks++;
    if (n != 0 || bus_if.pending !== 4'b0000) begin
      errors++;
      $display("FAIL coal_single_transfer: extra pulses=%0d pending=%b expected 0/0000", n, bus_if.pending);
    end
    bus_if.clrErr = 1'b1;
    step(1);
    bus_if.clrErr = 1'b0;
    checks++;
    if (bus_if.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL coal_clear: overflow=%b expected 0000", bus_if.overflow);
    end
    $display("test_coalesce done");
  endtask

  task automatic test_issue_cycle();
    bit         ok;
    logic [1:0] id;
    int         bad;
    apply_reset();
    bus_if.reqPulse = 4'b1000;
    step(1);
    bus_if.reqPulse = '0;
    wait_pulse(ok, id);                  // ISSUE cycle c
    checks++;
    if (!ok || id !== 2'd3) begin
      errors++;
      $display("FAIL issue_grant: ok=%0d chId=%0d expected ok=1 chId=3", ok, id);
    end
    bus_if.reqPulse = 4'b1000;
    bus_if.chAck = 1'b1;
    step(1);                             // c+1
    bus_if.reqPulse = '0;
    bus_if.chAck = 1'b0;
    checks++;
    if (bus_if.pending !== 4'b1000 || bus_if.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL issue_rearm: pending=%b overflow=%b expected 1000/0000", bus_if.pending, bus_if.overflow);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin    // c+1..c+5 must stay in one busy WAIT
      if (bus_if.busy !== 1'b1 || bus_if.chPulse !== 1'b0) bad++;
      step(1);
    end
    if (bus_if.busy !== 1'b1 || bus_if.chPulse !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL issue_ack_ignored: %0d off cycles expected 0", bad);
    end
    bus_if.chAck = 1'b1;                 // c+5
    step(1);
    bus_if.chAck = 1'b0;
    step(2);                             // c+8
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.chId !== 2'd3) begin
      errors++;
      $display("FAIL issue_idle: busy=%b chId=%0d expected 0/3", bus_if.busy, bus_if.chId);
    end
    wait_pulse(ok, id);
    checks++;
    if (!ok || id !== 2'd3) begin
      errors++;
      $display("FAIL issue_regrant: ok=%0d chId=%0d expected ok=1 chId=3", ok, id);
    end
    ack_after(1);
    $display("test_issue_cycle done");
  endtask

  task automatic test_timeout();
    bit         ok;
    logic [1:0] id;
    apply_reset();
    bus_if.reqPulse = 4'b0100;
    step(1);
    bus_if.reqPulse = '0;
    wait_pulse(ok, id);                  // ISSUE at c
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_grant: no chPulse within budget");
    end
    step(63);                            // c+63
    checks++;
    if (bus_if.timedOut !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: timedOut=%b busy=%b expected 0/1", bus_if.timedOut, bus_if.busy);
    end
    step(1);                             // c+64, GUARD
    checks++;
    if (bus_if.timedOut !== 1'b1) begin
      errors++;
      $display("FAIL to_set: timedOut=%b expected 1", bus_if.timedOut);
    end
    bus_if.chAck = 1'b1;
    step(1);                             // c+65
    bus_if.chAck = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_guard: busy=%b expected 1", bus_if.busy);
    end
    step(1);                             // c+66
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: busy=%b expected 0", bus_if.busy);
    end
    bus_if.chAck = 1'b1;
    step(1);
    bus_if.chAck = 1'b0;
    step(5);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.timedOut !== 1'b1) begin
      errors++;
      $display("FAIL to_late_ack: busy=%b timedOut=%b expected 0/1", bus_if.busy, bus_if.timedOut);
    end
    bus_if.clrErr = 1'b1;
    step(1);
    bus_if.clrErr = 1'b0;
    checks++;
    if (bus_if.timedOut !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: timedOut=%b expected 0", bus_if.timedOut);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_in_wait();
    bit         ok;
    logic [1:0] id;
    apply_reset();
    bus_if.reqPulse = 4'b0100;
    step(1);
    bus_if.reqPulse = '0;
    wait_pulse(ok, id);
    checks++;
    if (!ok || id !== 2'd2) begin
      errors++;
      $display("FAIL rw_grant: ok=%0d chId=%0d expected ok=1 chId=2", ok, id);
    end
    step(2);
    bus_if.reqPulse = 4'b1000;
    step(1);
    bus_if.reqPulse = '0;
    checks++;
    if (bus_if.pending !== 4'b1000) begin
      errors++;
      $display("FAIL rw_pending_before: got %b expected 1000", bus_if.pending);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++;
    if ({bus_if.chPulse, bus_if.busy, bus_if.timedOut, bus_if.chId, bus_if.pending, bus_if.overflow} !== 13'd0) begin
      errors++;
      $display("FAIL rw_cleared: chPulse=%b busy=%b timedOut=%b chId=%0d pending=%b overflow=%b expected all 0",
               bus_if.chPulse, bus_if.busy, bus_if.timedOut, bus_if.chId, bus_if.pending, bus_if.overflow);
    end
    bus_if.chAck = 1'b1;
    step(1);
    bus_if.chAck = 1'b0;
    step(2);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.chPulse !== 1'b0) begin
      errors++;
      $display("FAIL rw_late_ack: busy=%b chPulse=%b expected 0/0", bus_if.busy, bus_if.chPulse);
    end
    bus_if.reqPulse = 4'b1001;
    step(1);
    bus_if.reqPulse = '0;
    wait_pulse(ok, id);
    checks++;
    if (!ok || id !== 2'd0) begin
      errors++;
      $display("FAIL rw_rr_restart: ok=%0d chId=%0d expected ok=1 chId=0", ok, id);
    end
    ack_after(1);
    $display("test_reset_in_wait done");
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.reqPulse = '0;
    bus_if.chAck = 1'b0;
    bus_if.clrErr = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_coalesce();
    test_issue_cycle();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
